// File: rtl/pair_uart_printer_if.sv
// Pair handshake between the upstream transformer/sequencer and the UART printer.
`timescale 1ns/1ps
interface pair_uart_printer_if;
  logic       pair_valid;
  logic       pair_ready;
  logic [7:0] pair_lhs;
  logic [7:0] pair_rhs;
  logic       pair_last;

  modport master (output pair_valid, pair_lhs, pair_rhs, pair_last, input pair_ready);
  modport slave  (input pair_valid, pair_lhs, pair_rhs, pair_last, output pair_ready);
endinterface

// File: rtl/pair_uart_printer.sv
// Prints each (lhs, rhs) pair as "L>R" plus a space, or CR LF on the last pair,
// serialised as 8N1 UART on tx.
`timescale 1ns/1ps
module pair_uart_printer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  SEP_CHAR     = 8'h3E,
  parameter logic [7:0]  GAP_CHAR     = 8'h20
) (
  input  logic                clk,
  input  logic                rst,
  pair_uart_printer_if.slave  pair,
  output logic                tx,
  output logic                busy,
  output logic                line_done,
  output logic [7:0]          pair_count
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] TIMER_MAX = 16'(CLKS_PER_BIT - 1);

  state_t     state;
  logic [15:0] timer;
  logic [2:0] bit_idx;
  logic [2:0] char_idx;
  logic [7:0] lhs_q;
  logic [7:0] rhs_q;
  logic       last_q;
  logic [7:0] cur_char;
  logic [2:0] next_bit;
  logic [2:0] final_idx;
  logic       bit_end;

  assign pair.pair_ready = (state == IDLE) && !rst;
  assign busy            = (state != IDLE);
  assign bit_end         = (timer == TIMER_MAX);
  assign next_bit        = bit_idx + 3'd1;
  assign final_idx       = last_q ? 3'd4 : 3'd3;

  always_comb begin
    cur_char = 8'h0A;
    unique case (char_idx)
      3'd0:    cur_char = lhs_q;
      3'd1:    cur_char = SEP_CHAR;
      3'd2:    cur_char = rhs_q;
      3'd3:    cur_char = last_q ? 8'h0D : GAP_CHAR;
      default: cur_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      line_done  <= 1'b0;
      pair_count <= '0;
      timer      <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      lhs_q      <= '0;
      rhs_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      line_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pair.pair_valid) begin
            lhs_q      <= pair.pair_lhs;
            rhs_q      <= pair.pair_rhs;
            last_q     <= pair.pair_last;
            pair_count <= pair_count + 8'd1;
            char_idx   <= '0;
            timer      <= '0;
            tx         <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= '0;
            bit_idx <= '0;
            tx      <= cur_char[0];
            state   <= DATA;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit;
              tx      <= cur_char[next_bit];
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            timer <= '0;
            if (char_idx == final_idx) begin
              state <= IDLE;
              // Line completion clears the count on the same edge it pulses.
              if (last_q) begin
                line_done  <= 1'b1;
                pair_count <= '0;
              end
            end else begin
              char_idx <= char_idx + 3'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pair_uart_printer.sv
// Directed bench for pair_uart_printer with CLKS_PER_BIT=4 and a UART receiver model.
`timescale 1ns/1ps
module tb_pair_uart_printer;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic       busy;
  logic       line_done;
  logic [7:0] pair_count;

  pair_uart_printer_if pif();

  pair_uart_printer #(
    .CLKS_PER_BIT(C),
    .SEP_CHAR(8'h3E),
    .GAP_CHAR(8'h20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pair(pif.slave),
    .tx(tx),
    .busy(busy),
    .line_done(line_done),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ld_cycles = 0;
  int frame_errs = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  // Receiver: samples mid-bit on falling clock edges, drops partial frames on reset.
  logic       rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  always @(negedge clk) begin
    if (line_done) ld_cycles++;
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx == 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
        rx_byte = 8'h00;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= C && rx_cnt < 9*C && (rx_cnt % C) == C/2)
        rx_byte[(rx_cnt / C) - 1] = tx;
      if (rx_cnt == 9*C + C/2 && tx !== 1'b1) frame_errs++;
      if (rx_cnt == 10*C - 1) begin
        rx_q.push_back(rx_byte);
        rx_on = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    int n;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
    rx_q.delete();
  endtask

  // Counts falling edges with pair_ready low, starting at the current one.
  task automatic wait_ready(output int lows);
    lows = 0;
    while (pif.pair_ready !== 1'b1 && lows < 2000) begin
      lows++;
      @(negedge clk);
    end
  endtask

  // Called on a falling edge with pair_ready high; returns on the next falling edge.
  task automatic send(input string tag, input logic [7:0] l, input logic [7:0] r, input logic last);
    pif.pair_valid = 1'b1;
    pif.pair_lhs   = l;
    pif.pair_rhs   = r;
    pif.pair_last  = last;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_tx_fall"}, tx, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_ready_low"}, pif.pair_ready, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int ld0;
    int tx_lows;
    pif.pair_valid = 1'b0;
    pif.pair_lhs   = 8'h00;
    pif.pair_rhs   = 8'h00;
    pif.pair_last  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", pif.pair_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_line_done", line_done, 1'b0);
    check("rst_count", pair_count, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", pif.pair_ready, 1'b1);
    check("idle_tx", tx, 1'b1);

    // Single non-last pair
    rx_q.delete();
    ld0 = ld_cycles;
    send("t1", 8'h31, 8'h31, 1'b0);
    pif.pair_valid = 1'b0;
    check("t1_count", pair_count, 8'd1);
    wait_ready(lows);
    check("t1_ready_lows", lows, 160);
    check("t1_line_done", line_done, 1'b0);
    check("t1_count_end", pair_count, 8'd1);
    check("t1_ld_cycles", ld_cycles - ld0, 0);
    exp_q = '{8'h31, 8'h3E, 8'h31, 8'h20};
    check_rx("t1");

    // Last pair closes the line
    ld0 = ld_cycles;
    send("t2", 8'h5E, 8'h32, 1'b1);
    pif.pair_valid = 1'b0;
    check("t2_count", pair_count, 8'd2);
    wait_ready(lows);
    check("t2_ready_lows", lows, 200);
    check("t2_line_done", line_done, 1'b1);
    check("t2_count_clear", pair_count, 8'd0);
    @(negedge clk);
    check("t2_line_done_drop", line_done, 1'b0);
    check("t2_ld_cycles", ld_cycles - ld0, 1);
    exp_q = '{8'h5E, 8'h3E, 8'h32, 8'h0D, 8'h0A};
    check_rx("t2");

    // Back-to-back with valid held high
    ld0 = ld_cycles;
    send("t3a", 8'h61, 8'h62, 1'b0);
    check("t3a_count", pair_count, 8'd1);
    pif.pair_lhs = 8'h63;
    pif.pair_rhs = 8'h64;
    wait_ready(lows);
    check("t3a_ready_lows", lows, 160);
    send("t3b", 8'h63, 8'h64, 1'b0);
    check("t3b_count", pair_count, 8'd2);
    pif.pair_lhs  = 8'h65;
    pif.pair_rhs  = 8'h66;
    pif.pair_last = 1'b1;
    wait_ready(lows);
    check("t3b_ready_lows", lows, 160);
    send("t3c", 8'h65, 8'h66, 1'b1);
    check("t3c_count", pair_count, 8'd3);
    pif.pair_valid = 1'b0;
    wait_ready(lows);
    check("t3c_ready_lows", lows, 200);
    check("t3c_count_clear", pair_count, 8'd0);
    @(negedge clk);
    check("t3_ld_cycles", ld_cycles - ld0, 1);
    exp_q = '{8'h61, 8'h3E, 8'h62, 8'h20, 8'h63, 8'h3E, 8'h64, 8'h20,
              8'h65, 8'h3E, 8'h66, 8'h0D, 8'h0A};
    check_rx("t3");

    // Changing data while busy is ignored
    send("t4a", 8'h41, 8'h42, 1'b0);
    lows = 0;
    while (pif.pair_ready !== 1'b1 && lows < 2000) begin
      pif.pair_lhs  = 8'($urandom);
      pif.pair_rhs  = 8'($urandom);
      pif.pair_last = 1'($urandom);
      lows++;
      @(negedge clk);
    end
    check("t4a_ready_lows", lows, 160);
    check("t4a_count", pair_count, 8'd1);
    send("t4b", 8'h43, 8'h44, 1'b0);
    pif.pair_valid = 1'b0;
    check("t4b_count", pair_count, 8'd2);
    wait_ready(lows);
    check("t4b_ready_lows", lows, 160);
    exp_q = '{8'h41, 8'h3E, 8'h42, 8'h20, 8'h43, 8'h3E, 8'h44, 8'h20};
    check_rx("t4");

    // Reset in the middle of the second character's data bits
    send("t5", 8'h55, 8'h66, 1'b0);
    pif.pair_valid = 1'b0;
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_tx", tx, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_count", pair_count, 8'd0);
    check("t5_rst_ready", pif.pair_ready, 1'b0);
    @(negedge clk);
    check("t5_rst_ready_held", pif.pair_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_ready_after", pif.pair_ready, 1'b1);
    check("t5_busy_after", busy, 1'b0);
    tx_lows = 0;
    repeat (80) begin
      if (tx !== 1'b1) tx_lows++;
      @(negedge clk);
    end
    check("t5_tx_quiet", tx_lows, 0);
    exp_q = '{8'h55};
    check_rx("t5");

    // 256 non-last pairs wrap the counter
    ld0 = ld_cycles;
    for (int i = 0; i < 256; i++) begin
      send("t6", 8'(i), 8'(255 - i), 1'b0);
      pif.pair_valid = 1'b0;
      check($sformatf("t6_count%0d", i), pair_count, 32'((i + 1) % 256));
      wait_ready(lows);
      if (i == 255) check("t6_last_ready_lows", lows, 160);
    end
    check("t6_count_wrapped", pair_count, 8'd0);
    check("t6_ld_cycles", ld_cycles - ld0, 0);
    check("frame_errs", frame_errs, 0);
    rx_q.delete();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
